// File: rtl/note_synth.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// note_synth -- square-wave note player with a one-entry next-note buffer.
//
// A note is {note_word, note_len}: note_word is the phase increment added on
// every audio sample (0 = rest) and note_len is the duration in units of 256
// samples (0 = 256 units, i.e. 65536 samples). The output is a square wave
// whose sign follows phase bit 15 and whose magnitude is volume << 11.
//
// Build option: define NOTE_GAP_EN to silence the final 64 samples of every
// note (GAP state) for articulation between consecutive notes.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sample_en  in   one-cycle strobe at the audio sample rate
//   pause      in   level, 1 freezes playback and mutes the output
//   note_valid in   upstream offers a note
//   note_ready out  next-note buffer empty (handshake with note_valid)
//   note_word  in   [15:0] phase increment per sample
//   note_len   in   [7:0]  duration in 256-sample units, 0 = 256
//   volume     in   [3:0]  amplitude step, used live
//   audio_out  out  [15:0] signed sample, registered
//   playing    out  1 whenever the player is not idle
//   underrun   out  one-cycle pulse when a note ends without a successor
// ---------------------------------------------------------------------------
module note_synth (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_en,
  input  logic               pause,
  input  logic               note_valid,
  output logic               note_ready,
  input  logic [15:0]        note_word,
  input  logic [7:0]         note_len,
  input  logic [3:0]         volume,
  output logic signed [15:0] audio_out,
  output logic               playing,
  output logic               underrun
);

`ifdef NOTE_GAP_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1} state_t;
`endif

  state_t             state_q, state_d;
  logic               buf_full_q, buf_full_d;
  logic [15:0]        buf_word_q, buf_word_d;
  logic [7:0]         buf_len_q, buf_len_d;
  logic [15:0]        cur_word_q, cur_word_d;
  logic [15:0]        phase_q, phase_d;
  logic [15:0]        cnt_q, cnt_d;
  logic signed [15:0] audio_q, audio_d;
  logic               underrun_q, underrun_d;

  logic               accept;
  logic               taken;
  logic               load;
  logic [15:0]        load_word;
  logic [7:0]         load_len;
  logic               in_gap;

  // Square-wave sample from the pre-update phase; a rest note is silent
  // even though its phase never leaves the positive half.
  function automatic logic signed [15:0] tone_sample(input logic [15:0] word,
                                                     input logic [15:0] phase,
                                                     input logic [3:0]  vol);
    logic signed [15:0] amp;
    amp = $signed({1'b0, vol, 11'b0});
    if (word == 16'h0000)
      return 16'sd0;
    return phase[15] ? -amp : amp;
  endfunction

  // Samples remaining minus one; len=0 wraps to 65535, giving 65536 samples.
  function automatic logic [15:0] len_to_count(input logic [7:0] len);
    return {len, 8'h00} - 16'd1;
  endfunction

`ifdef NOTE_GAP_EN
  assign in_gap = (state_q == ST_GAP);
`else
  assign in_gap = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_word_d = buf_word_q;
    buf_len_d  = buf_len_q;
    cur_word_d = cur_word_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    audio_d    = audio_q;
    underrun_d = 1'b0;
    accept     = note_valid && !buf_full_q;
    taken      = 1'b0;
    load       = 1'b0;
    load_word  = buf_word_q;
    load_len   = buf_len_q;

    case (state_q)
      ST_IDLE: begin
        audio_d = 16'sd0;
        // An idle player takes an offered note straight into the current
        // registers so it is playing on the very next cycle. While paused
        // the state is frozen, so the note waits in the buffer instead.
        if (!pause) begin
          if (buf_full_q) begin
            load       = 1'b1;
            buf_full_d = 1'b0;
          end else if (accept) begin
            load      = 1'b1;
            taken     = 1'b1;
            load_word = note_word;
            load_len  = note_len;
          end
        end
      end
`ifdef NOTE_GAP_EN
      ST_PLAY, ST_GAP: begin
`else
      ST_PLAY: begin
`endif
        if (sample_en && !pause) begin
          audio_d = in_gap ? 16'sd0 : tone_sample(cur_word_q, phase_q, volume);
          phase_d = phase_q + cur_word_q;
          cnt_d   = cnt_q - 16'd1;
          // The final sample is still emitted; the player goes silent via
          // IDLE on the following cycle when there is no successor.
          if (cnt_q == 16'd0) begin
            if (buf_full_q) begin
              load       = 1'b1;
              buf_full_d = 1'b0;
            end else if (note_valid) begin
              load      = 1'b1;
              taken     = 1'b1;
              load_word = note_word;
              load_len  = note_len;
            end else begin
              underrun_d = 1'b1;
              state_d    = ST_IDLE;
            end
          end
`ifdef NOTE_GAP_EN
          if (cnt_q != 16'd0 && cnt_d < 16'd64)
            state_d = ST_GAP;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d    = ST_PLAY;
      cur_word_d = load_word;
      phase_d    = 16'h0000;
      cnt_d      = len_to_count(load_len);
    end

    // A note consumed by a direct load must not also land in the buffer.
    if (accept && !taken) begin
      buf_full_d = 1'b1;
      buf_word_d = note_word;
      buf_len_d  = note_len;
    end

    if (pause)
      audio_d = 16'sd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      buf_full_q <= 1'b0;
      phase_q    <= 16'h0000;
      cnt_q      <= 16'h0000;
      audio_q    <= 16'sd0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      audio_q    <= audio_d;
      underrun_q <= underrun_d;
    end
  end

  // Note payload registers are only meaningful once qualified by
  // buf_full_q / a non-idle state, so they carry no reset.
  always_ff @(posedge clk) begin
    buf_word_q <= buf_word_d;
    buf_len_q  <= buf_len_d;
    cur_word_q <= cur_word_d;
  end

  assign note_ready = !buf_full_q;
  assign playing    = (state_q != ST_IDLE);
  assign underrun   = underrun_q;
  assign audio_out  = audio_q;

endmodule
